// File: rtl/buzzer_tone_gen_if.sv
// Note-fetch handshake from the music ROM controller plus the buzzer-side outputs.
// The master drives note/volume/control; the slave is the tone generator.
interface buzzer_tone_gen_if;
  logic       tran_vld;
  logic       tran_end;
  logic [5:0] q;
  logic [9:0] volume_in;
  logic       buzzer;
  logic       playing;

  modport master (output tran_vld, tran_end, q, volume_in, input buzzer, playing);
  modport slave  (input tran_vld, tran_end, q, volume_in, output buzzer, playing);
endinterface

// File: rtl/buzzer_tone_gen.sv
// Latches ROM note codes and drives a passive buzzer with a PWM square wave at the note pitch,
// preceded by a silent articulation gap.
//
// state | meaning
// IDLE  | silent, waiting for a note fetch
// GAP   | silent articulation gap at note start
// PLAY  | PWM tone at latched period/duty until next note or stop
module buzzer_tone_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int GAP_CYC = 500_000,
  parameter int PER_W   = 18
) (
  input logic              sysclk,
  input logic              rst_n,
  buzzer_tone_gen_if.slave bus
);
  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int PROD_W   = PER_W + 10;
  localparam bit TABLE_OK = (CLK_HZ == 50_000_000);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    GAP  = 3'b010,
    PLAY = 3'b100
  } state_t;

  state_t             state;
  logic               vld_d;
  logic               buzzer_r;
  logic               playing_r;
  logic [GAP_W-1:0]   gap_cnt;
  logic [PER_W-1:0]   per;
  logic [PER_W-1:0]   per_cnt;
  logic [PER_W-1:0]   h;
  logic [17:0]        base;
  logic [1:0]         oct;
  logic [PER_W-1:0]   p_tab;
  logic [PER_W-1:0]   mul_a;
  logic [PROD_W-1:0]  prod;
  logic [PER_W-1:0]   h_new;

  assign oct         = bus.q[5:4];
  assign bus.buzzer  = buzzer_r;
  assign bus.playing = playing_r;

  // Rests and control codes map to period 0, which forces H=0 and a silent PLAY.
  always_comb begin
    base = '0;
    case (bus.q[3:0])
      4'd1:    base = 18'd191113;
      4'd2:    base = 18'd180388;
      4'd3:    base = 18'd170265;
      4'd4:    base = 18'd160705;
      4'd5:    base = 18'd151685;
      4'd6:    base = 18'd143172;
      4'd7:    base = 18'd135139;
      4'd8:    base = 18'd127551;
      4'd9:    base = 18'd120395;
      4'd10:   base = 18'd113636;
      4'd11:   base = 18'd107259;
      4'd12:   base = 18'd101238;
      default: base = '0;
    endcase
    p_tab = '0;
    if (TABLE_OK && oct != 2'd3) p_tab = PER_W'(base >> oct);
    mul_a = vld_d ? p_tab : per;
    prod  = PROD_W'(mul_a) * PROD_W'(bus.volume_in);
    h_new = prod[PROD_W-1:10];
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vld_d     <= 1'b0;
      buzzer_r  <= 1'b0;
      playing_r <= 1'b0;
      gap_cnt   <= '0;
      per       <= '0;
      per_cnt   <= '0;
      h         <= '0;
    end else begin
      vld_d <= bus.tran_vld & ~bus.tran_end;
      if (bus.tran_end) begin
        state     <= IDLE;
        vld_d     <= 1'b0;
        buzzer_r  <= 1'b0;
        playing_r <= 1'b0;
        gap_cnt   <= '0;
        per_cnt   <= '0;
      end else if (vld_d) begin
        state     <= GAP;
        per       <= p_tab;
        h         <= h_new;
        gap_cnt   <= '0;
        per_cnt   <= '0;
        buzzer_r  <= 1'b0;
        playing_r <= 1'b1;
      end else begin
        case (state)
          GAP: begin
            buzzer_r <= 1'b0;
            if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
              state    <= PLAY;
              per_cnt  <= '0;
              buzzer_r <= (h != '0);
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          PLAY: begin
            // Duty is refreshed only on the wrap so a volume change never chops a pulse.
            if (per_cnt == per - PER_W'(1)) begin
              per_cnt  <= '0;
              h        <= h_new;
              buzzer_r <= (h_new != '0);
            end else begin
              per_cnt  <= per_cnt + PER_W'(1);
              buzzer_r <= ((per_cnt + PER_W'(1)) < h);
            end
          end
          default: begin
            state     <= IDLE;
            buzzer_r  <= 1'b0;
            playing_r <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
